// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

  localparam int IW_DEF = 12;
  localparam int OP_W = 3;
  localparam logic [2:0] HALT_OP_DEF = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program buffer: synchronous write, combinational read.
module seq_prog_mem
  import seq_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];

  // buffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issuer driving a valid/ready instruction interface from a loadable buffer.
// Build option SEQ_LOOP_EN: the program wraps at its end instead of finishing.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int         IW        = IW_DEF,
  parameter int         DEPTH     = 8,
  parameter int         AW        = 3,
  parameter logic [2:0] HALT_OP   = HALT_OP_DEF,
  parameter int         ISSUE_GAP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stop,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issued_cnt
);

  localparam logic [1:0] GAP_INIT = 2'((ISSUE_GAP > 0) ? (ISSUE_GAP - 1) : 0);

  state_t        state_r, state_s;
  logic [IW-1:0] instr_s, rd_data_s, fetch_s;
  logic          valid_s, busy_s, done_s;
  logic [AW-1:0] pc_s, next_pc_s, rd_addr_s;
  logic [7:0]    cnt_s;
  logic [AW:0]   len_r, len_s;
  logic [1:0]    gap_r, gap_s;
  logic          idle_s, xfer_s, halt_s, last_s, end_s, we_s;

  seq_prog_mem #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we_s),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // transfer decode and fetch address selection
  always_comb begin
    idle_s = (state_r == IDLE) || (state_r == DONE);
    xfer_s = instr_valid & instr_ready;
    halt_s = (instr[IW-1:IW-OP_W] == HALT_OP);
    last_s = ({1'b0, pc} == (len_r - {{AW{1'b0}}, 1'b1}));
    we_s   = load_en & idle_s;
`ifdef SEQ_LOOP_EN
    end_s  = halt_s;
`else
    end_s  = halt_s | last_s;
`endif
    if (last_s) begin
      next_pc_s = '0;
    end else begin
      next_pc_s = pc + {{(AW-1){1'b0}}, 1'b1};
    end
    case (state_r)
      ISSUE:   rd_addr_s = next_pc_s;
      GAP:     rd_addr_s = pc;
      default: rd_addr_s = '0;
    endcase
    // a load landing on the start edge must be visible in the first instruction
    if (we_s && (load_addr == rd_addr_s)) begin
      fetch_s = load_data;
    end else begin
      fetch_s = rd_data_s;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_s = state_r;
    instr_s = instr;
    valid_s = instr_valid;
    pc_s    = pc;
    cnt_s   = issued_cnt;
    len_s   = len_r;
    gap_s   = gap_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          pc_s  = '0;
          cnt_s = 8'd0;
          len_s = prog_len;
          if (prog_len == {(AW+1){1'b0}}) begin
            state_s = DONE;
            valid_s = 1'b0;
          end else begin
            state_s = ISSUE;
            instr_s = fetch_s;
            valid_s = 1'b1;
          end
        end else begin
          valid_s = 1'b0;
        end
      end
      ISSUE: begin
        if (xfer_s) begin
          cnt_s = issued_cnt + 8'd1;
          if (end_s || stop) begin
            state_s = DONE;
            valid_s = 1'b0;
          end else begin
            pc_s = next_pc_s;
            if (ISSUE_GAP == 0) begin
              instr_s = fetch_s;
              valid_s = 1'b1;
            end else begin
              state_s = GAP;
              valid_s = 1'b0;
              gap_s   = GAP_INIT;
            end
          end
        end else if (stop) begin
          state_s = DONE;
          valid_s = 1'b0;
        end else begin
          valid_s = instr_valid;
        end
      end
      GAP: begin
        if (stop) begin
          state_s = DONE;
        end else if (gap_r == 2'd0) begin
          state_s = ISSUE;
          instr_s = fetch_s;
          valid_s = 1'b1;
        end else begin
          gap_s = gap_r - 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s == ISSUE) || (state_s == GAP);
    done_s = (state_s == DONE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issued_cnt  <= 8'd0;
      len_r       <= '0;
      gap_r       <= 2'd0;
    end else begin
      state_r     <= state_s;
      instr       <= instr_s;
      instr_valid <= valid_s;
      pc          <= pc_s;
      busy        <= busy_s;
      done        <= done_s;
      issued_cnt  <= cnt_s;
      len_r       <= len_s;
      gap_r       <= gap_s;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench; a second instance runs with ISSUE_GAP=2 on the same stimulus.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, load_en, start, stop, instr_ready;
  logic [2:0]  load_addr;
  logic [11:0] load_data;
  logic [3:0]  prog_len;
  logic [11:0] instr, g_instr;
  logic        instr_valid, busy, done, g_instr_valid, g_busy, g_done;
  logic [2:0]  pc, g_pc;
  logic [7:0]  issued_cnt, g_issued_cnt;
  logic [7:0]  gv;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stop(stop), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .busy(busy), .done(done), .issued_cnt(issued_cnt)
  );

  instr_sequencer #(.ISSUE_GAP(2)) gdut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .start(start), .stop(stop), .instr(g_instr), .instr_valid(g_instr_valid),
    .instr_ready(instr_ready), .pc(g_pc), .busy(g_busy), .done(g_done), .issued_cnt(g_issued_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [11:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic go(input logic [3:0] len);
    prog_len = len; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((busy || g_busy) && n < 60) begin
      step();
      n++;
    end
    chk("settle_timeout", {31'd0, busy | g_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = 3'd0; load_data = 12'h000;
    prog_len = 4'd0; start = 1'b0; stop = 1'b0; instr_ready = 1'b0;
    step(); step();
    chk("rst_instr", instr, 12'h000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", issued_cnt, 8'd0);
    rst = 1'b0;

`ifndef SEQ_LOOP_EN
    load(3'd0, 12'h03C); load(3'd1, 12'h04F); load(3'd2, 12'h20A);
    instr_ready = 1'b1;
    go(4'd3);
    gv[0] = g_instr_valid;
    chk("b2b_i0", instr, 12'h03C); chk("b2b_v0", instr_valid, 1'b1);
    chk("b2b_pc0", pc, 3'd0); chk("b2b_busy", busy, 1'b1);
    step(); gv[1] = g_instr_valid;
    chk("b2b_i1", instr, 12'h04F); chk("b2b_pc1", pc, 3'd1);
    chk("b2b_v1", instr_valid, 1'b1); chk("b2b_cnt1", issued_cnt, 8'd1);
    step(); gv[2] = g_instr_valid;
    chk("b2b_i2", instr, 12'h20A); chk("b2b_pc2", pc, 3'd2); chk("b2b_cnt2", issued_cnt, 8'd2);
    step(); gv[3] = g_instr_valid;
    chk("gap_i1", g_instr, 12'h04F);
    chk("b2b_vend", instr_valid, 1'b0); chk("b2b_done", done, 1'b1);
    chk("b2b_busyend", busy, 1'b0); chk("b2b_cnt3", issued_cnt, 8'd3);
    chk("b2b_ihold", instr, 12'h20A);
    for (int k = 4; k < 8; k++) begin
      step();
      gv[k] = g_instr_valid;
    end
    chk("gap_pattern", gv, 8'b0100_1001);
    chk("gap_done", g_done, 1'b1);
    chk("gap_cnt", g_issued_cnt, 8'd3);
    settle();

    go(4'd3);
    step();
    instr_ready = 1'b0;
    step();
    chk("stall_i_a", instr, 12'h04F); chk("stall_pc_a", pc, 3'd1); chk("stall_v_a", instr_valid, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_pc", pc, 3'd1); chk("busy_start_cnt", issued_cnt, 8'd1);
    chk("stall_i_b", instr, 12'h04F);
    step();
    chk("stall_i_c", instr, 12'h04F); chk("stall_pc_c", pc, 3'd1);
    instr_ready = 1'b1;
    step();
    chk("stall_i2", instr, 12'h20A); chk("stall_cnt2", issued_cnt, 8'd2);
    step();
    chk("stall_done", done, 1'b1); chk("stall_cnt3", issued_cnt, 8'd3);
    settle();
`else
    load(3'd0, 12'h03C); load(3'd1, 12'h04F);
    instr_ready = 1'b1;
    go(4'd2);
    chk("loop_pc0", pc, 3'd0);
    step(); chk("loop_pc1", pc, 3'd1);
    step(); chk("loop_pc2", pc, 3'd0); chk("loop_i2", instr, 12'h03C);
    step(); chk("loop_pc3", pc, 3'd1);
    chk("loop_cnt", issued_cnt, 8'd3); chk("loop_busy", busy, 1'b1); chk("loop_notdone", done, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("loop_stop_done", done, 1'b1); chk("loop_stop_v", instr_valid, 1'b0);
    settle();
`endif

    load(3'd0, 12'h03C); load(3'd1, 12'hE00); load(3'd2, 12'h20A);
    instr_ready = 1'b1;
    go(4'd3);
    step();
    chk("halt_i", instr, 12'hE00); chk("halt_v", instr_valid, 1'b1);
    step();
    chk("halt_done", done, 1'b1); chk("halt_v_end", instr_valid, 1'b0);
    chk("halt_cnt", issued_cnt, 8'd2); chk("halt_ihold", instr, 12'hE00);
    step();
    chk("halt_noissue", {20'd0, instr_valid, instr}, {20'd0, 1'b0, 12'hE00});
    settle();
    chk("gap_halt_cnt", g_issued_cnt, 8'd2);

    go(4'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_cnt", issued_cnt, 8'd1); chk("stop_done", done, 1'b1);
    chk("stop_v", instr_valid, 1'b0); chk("stop_busy", busy, 1'b0);
    chk("gap_stop_cnt", g_issued_cnt, 8'd1); chk("gap_stop_done", g_done, 1'b1);
    settle();

    go(4'd0);
    chk("len0_done", done, 1'b1); chk("len0_busy", busy, 1'b0);
    chk("len0_v", instr_valid, 1'b0); chk("len0_cnt", issued_cnt, 8'd0);

    load_en = 1'b1; load_addr = 3'd0; load_data = 12'h123;
    go(4'd3);
    load_en = 1'b0;
    chk("fwd_i", instr, 12'h123); chk("fwd_v", instr_valid, 1'b1);
    step();
    chk("mid_i", instr, 12'hE00); chk("mid_pc", pc, 3'd1);
    instr_ready = 1'b0; rst = 1'b1;
    step();
    chk("mrst_v", instr_valid, 1'b0); chk("mrst_pc", pc, 3'd0);
    chk("mrst_busy", busy, 1'b0); chk("mrst_done", done, 1'b0);
    chk("mrst_cnt", issued_cnt, 8'd0); chk("mrst_i", instr, 12'h000);
    step();
    rst = 1'b0;
    step();
    chk("mrst_idle_v", instr_valid, 1'b0); chk("gap_mrst_busy", g_busy, 1'b0);

    go(4'd1);
    chk("keep_i", instr, 12'h123);
    load_en = 1'b1; load_addr = 3'd0; load_data = 12'h555;
    step();
    load_en = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    settle();
    go(4'd1);
    chk("busyload_i", instr, 12'h123);
    stop = 1'b1;
    step();
    stop = 1'b0;
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
